ips2l_pcie_dma_rx_cpld_wr_ctrl: RTL and testbench



---
 rtl/ips2l_pcie_dma_pkg.sv | 37 +++
 rtl/ips2l_pcie_dma_rx_dw_align.sv | 79 +++++++
 rtl/ips2l_pcie_dma_rx_cpld_wr_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ips2l_pcie_dma_rx_cpld_wr_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ips2l_pcie_dma_pkg.sv
// rtl/ips2l_pcie_dma_pkg.sv - shared constants and helpers for the PCIe DMA RX write path
//
// Purpose: FSM state encodings, line geometry constants and the per-DW
//          byte-enable builder used by the CplD-to-BAR-RAM write path.
// Ports:   none (package).

package ips2l_pcie_dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int DW_PER_LINE = 4;
  localparam int BE_W        = 16;

  // Byte enables for one packed beat. valid_mask is contiguous from lane 0.
  // first_be trims lane 0 and last_be trims the highest valid lane; callers
  // pass 4'hF when the beat holds neither the first nor the last payload DW.
  function automatic logic [BE_W-1:0] dw_be(input logic [3:0] valid_mask,
                                            input logic [3:0] first_be,
                                            input logic [3:0] last_be);
    logic [BE_W-1:0] be;
    logic [3:0]      b;
    be = '0;
    for (int i = 0; i < DW_PER_LINE; i++) begin
      b = 4'h0;
      if (valid_mask[i]) begin
        b = 4'hF;
        if (i == 0) b = b & first_be;
        if ((valid_mask >> (i + 1)) == 4'd0) b = b & last_be;
      end
      be[4*i +: 4] = b;
    end
    return be;
  endfunction

endpackage

// File: rtl/ips2l_pcie_dma_rx_dw_align.sv
// rtl/ips2l_pcie_dma_rx_dw_align.sv - realigns packed payload DWs to the target DW offset
//
// Purpose: shifts a lane-0 packed beat up by the DW offset, filling the low
//          lanes from the previous beat (residue). A flush cycle emits the
//          residue lanes only.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_clr           clear residue (new TLP)
//   i_load          capture current beat as residue (beat accepted)
//   i_beat_data     packed beat, DW0 in bits [31:0]
//   i_beat_vmask    valid DW lanes of the beat
//   i_first_be      byte enables applied to lane 0 of the beat
//   i_last_be       byte enables applied to the highest valid lane
//   i_off           target DW offset within the 128-bit line
//   i_first         first write of the TLP: lanes below the offset disabled
//   i_flush         residue-only write
//   o_data, o_be    aligned line data and byte enables

module ips2l_pcie_dma_rx_dw_align
  import ips2l_pcie_dma_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_load,
  input  logic [127:0]    i_beat_data,
  input  logic [3:0]      i_beat_vmask,
  input  logic [3:0]      i_first_be,
  input  logic [3:0]      i_last_be,
  input  logic [1:0]      i_off,
  input  logic            i_first,
  input  logic            i_flush,
  output logic [127:0]    o_data,
  output logic [BE_W-1:0] o_be
);

  logic [BE_W-1:0] w_beat_be;
  logic [127:0]    r_res_data;
  logic [BE_W-1:0] r_res_be;
  logic [1:0]      w_src;

  assign w_beat_be = dw_be(i_beat_vmask, i_first_be, i_last_be);

  // The whole beat is kept; only lanes 4-off..3 are ever read back.
  // Invalid lanes carry zero enables, so a short final beat cannot leak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data <= '0;
      r_res_be   <= '0;
    end else if (i_clr) begin
      r_res_data <= '0;
      r_res_be   <= '0;
    end else if (i_load) begin
      r_res_data <= i_beat_data;
      r_res_be   <= w_beat_be;
    end
  end

  // Output lane j takes source lane (j - off) mod 4: from the current beat
  // when j >= off, otherwise from the residue of the previous beat.
  always_comb begin
    o_data = '0;
    o_be   = '0;
    w_src  = '0;
    for (int j = 0; j < DW_PER_LINE; j++) begin
      w_src = 2'(j) - i_off;
      if (2'(j) >= i_off) begin
        if (!i_flush) begin
          o_data[32*j +: 32] = i_beat_data[32*w_src +: 32];
          o_be[4*j +: 4]     = w_beat_be[4*w_src +: 4];
        end
      end else if (!i_first) begin
        o_data[32*j +: 32] = r_res_data[32*w_src +: 32];
        o_be[4*j +: 4]     = r_res_be[4*w_src +: 4];
      end
    end
  end

endmodule

// File: rtl/ips2l_pcie_dma_rx_cpld_wr_ctrl.sv
// rtl/ips2l_pcie_dma_rx_cpld_wr_ctrl.sv - writes CplD payload beats into the 128-bit BAR RAM
//
// Purpose: per-TLP FSM (IDLE/DATA/FLUSH), DW countdown, line address
//          generation and registered RAM write port.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   i_cpld_start/length/dw_addr         TLP descriptor (length 0 = 1024 DW)
//   i_first_be, i_last_be               first/last DW byte enables
//   i_cpld_valid/data/last, o_cpld_ready payload beat handshake
//   o_ram_wr_en/addr/data/be            BAR RAM write port (registered)
//   o_wr_busy, o_wr_done, o_len_err     status

module ips2l_pcie_dma_rx_cpld_wr_ctrl
  import ips2l_pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cpld_start,
  input  logic [9:0]            i_cpld_length,
  input  logic [ADDR_WIDTH+1:0] i_cpld_dw_addr,
  input  logic [3:0]            i_first_be,
  input  logic [3:0]            i_last_be,
  input  logic                  i_cpld_valid,
  input  logic [127:0]          i_cpld_data,
  input  logic                  i_cpld_last,
  output logic                  o_cpld_ready,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic [127:0]          o_ram_wr_data,
  output logic [BE_W-1:0]       o_ram_wr_be,
  output logic                  o_wr_busy,
  output logic                  o_wr_done,
  output logic                  o_len_err
);

  logic [1:0]            r_state;
  logic [10:0]           r_remain;
  logic [ADDR_WIDTH-1:0] r_line;
  logic [1:0]            r_off;
  logic [3:0]            r_first_be;
  logic [3:0]            r_last_be;
  logic                  r_single;
  logic                  r_first;
  logic                  r_need_flush;
  logic                  r_busy;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [127:0]          r_wr_data;
  logic [BE_W-1:0]       r_wr_be;
  logic                  r_wr_done;
  logic                  r_len_err;

  logic            w_start_acc;
  logic [10:0]     w_start_len;
  logic [1:0]      w_tail;
  logic            w_need_flush;
  logic            w_accept;
  logic            w_expect_last;
  logic            w_len_bad;
  logic [2:0]      w_n;
  logic [3:0]      w_vmask;
  logic [127:0]    w_al_data;
  logic [BE_W-1:0] w_al_be;

  assign w_start_acc = (r_state == ST_IDLE) && i_cpld_start;
  assign w_start_len = (i_cpld_length == 10'd0) ? 11'd1024 : {1'b0, i_cpld_length};

  // One extra line is needed when offset plus the DWs in the final beat
  // spill past lane 3: off + ((L-1) mod 4) >= 4.
  assign w_tail       = w_start_len[1:0] - 2'd1;
  assign w_need_flush = ({1'b0, i_cpld_dw_addr[1:0]} + {1'b0, w_tail}) >= 3'd4;

  assign w_accept      = (r_state == ST_DATA) && i_cpld_valid;
  assign w_expect_last = (r_remain <= 11'd4);
  assign w_len_bad     = w_accept && (i_cpld_last != w_expect_last);
  assign w_n           = (r_remain >= 11'd4) ? 3'd4 : r_remain[2:0];

  always_comb begin
    w_vmask = '0;
    for (int i = 0; i < DW_PER_LINE; i++) begin
      w_vmask[i] = (3'(i) < w_n);
    end
  end

  ips2l_pcie_dma_rx_dw_align u_align (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_start_acc),
    .i_load       (w_accept && !w_len_bad),
    .i_beat_data  (i_cpld_data),
    .i_beat_vmask (w_vmask),
    .i_first_be   (r_first ? r_first_be : 4'hF),
    .i_last_be    ((w_expect_last && !r_single) ? r_last_be : 4'hF),
    .i_off        (r_off),
    .i_first      (r_first),
    .i_flush      (r_state == ST_FLUSH),
    .o_data       (w_al_data),
    .o_be         (w_al_be)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_remain     <= '0;
      r_line       <= '0;
      r_off        <= '0;
      r_first_be   <= '0;
      r_last_be    <= '0;
      r_single     <= 1'b0;
      r_first      <= 1'b0;
      r_need_flush <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_be      <= '0;
      r_wr_done    <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_done <= 1'b0;
      r_len_err <= 1'b0;

      // Busy falls one cycle after the done pulse, or with the error pulse.
      if (w_start_acc)                  r_busy <= 1'b1;
      else if (r_wr_done || w_len_bad)  r_busy <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_cpld_start) begin
            r_line       <= i_cpld_dw_addr[ADDR_WIDTH+1:2];
            r_off        <= i_cpld_dw_addr[1:0];
            r_remain     <= w_start_len;
            r_first_be   <= i_first_be;
            r_last_be    <= i_last_be;
            r_single     <= (w_start_len == 11'd1);
            r_need_flush <= w_need_flush;
            r_first      <= 1'b1;
            r_state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            if (w_len_bad) begin
              r_len_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_line;
              r_wr_data <= w_al_data;
              r_wr_be   <= w_al_be;
              r_line    <= r_line + 1'b1;
              r_first   <= 1'b0;
              r_remain  <= r_remain - {8'd0, w_n};
              if (w_expect_last) begin
                if (r_need_flush) begin
                  r_state <= ST_FLUSH;
                end else begin
                  r_wr_done <= 1'b1;
                  r_state   <= ST_IDLE;
                end
              end
            end
          end
        end
        ST_FLUSH: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_line;
          r_wr_data <= w_al_data;
          r_wr_be   <= w_al_be;
          r_wr_done <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpld_ready  = (r_state == ST_DATA);
  assign o_ram_wr_en   = r_wr_en;
  assign o_ram_wr_addr = r_wr_addr;
  assign o_ram_wr_data = r_wr_data;
  assign o_ram_wr_be   = r_wr_be;
  assign o_wr_busy     = r_busy;
  assign o_wr_done     = r_wr_done;
  assign o_len_err     = r_len_err;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_cpld_wr_ctrl.sv
// tb/tb_ips2l_pcie_dma_rx_cpld_wr_ctrl.sv - self-checking bench for the CplD BAR RAM writer

module tb_ips2l_pcie_dma_rx_cpld_wr_ctrl;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_cpld_start = 1'b0;
  logic [9:0]    i_cpld_length = '0;
  logic [AW+1:0] i_cpld_dw_addr = '0;
  logic [3:0]    i_first_be = '0;
  logic [3:0]    i_last_be = '0;
  logic          i_cpld_valid = 1'b0;
  logic [127:0]  i_cpld_data = '0;
  logic          i_cpld_last = 1'b0;
  logic          o_cpld_ready;
  logic          o_ram_wr_en;
  logic [AW-1:0] o_ram_wr_addr;
  logic [127:0]  o_ram_wr_data;
  logic [15:0]   o_ram_wr_be;
  logic          o_wr_busy;
  logic          o_wr_done;
  logic          o_len_err;

  always #5 clk = ~clk;

  ips2l_pcie_dma_rx_cpld_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cpld_start   (i_cpld_start),
    .i_cpld_length  (i_cpld_length),
    .i_cpld_dw_addr (i_cpld_dw_addr),
    .i_first_be     (i_first_be),
    .i_last_be      (i_last_be),
    .i_cpld_valid   (i_cpld_valid),
    .i_cpld_data    (i_cpld_data),
    .i_cpld_last    (i_cpld_last),
    .o_cpld_ready   (o_cpld_ready),
    .o_ram_wr_en    (o_ram_wr_en),
    .o_ram_wr_addr  (o_ram_wr_addr),
    .o_ram_wr_data  (o_ram_wr_data),
    .o_ram_wr_be    (o_ram_wr_be),
    .o_wr_busy      (o_wr_busy),
    .o_wr_done      (o_wr_done),
    .o_len_err      (o_len_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [127:0]  data;
    logic [15:0]   be;
  } wr_t;

  typedef struct {
    int          addr;
    int          len;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    int          nwr;
    int          a0;
    logic [15:0] be0;
    int          alast;
    logic [15:0] belast;
  } vec_t;

  wr_t         wr_q[$];
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] payload [0:1023];
  vec_t        vecs [7];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cnt, err_cnt, done_idx, done_cyc, err_cyc, fall_cyc, first_wr_cyc, first_acc_cyc;
  logic done_with_wr;
  logic prev_busy = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (o_ram_wr_en) begin
      mon_w.addr = o_ram_wr_addr;
      mon_w.data = o_ram_wr_data;
      mon_w.be   = o_ram_wr_be;
      if (wr_q.size() == 0) first_wr_cyc = cyc;
      wr_q.push_back(mon_w);
    end
    if (o_wr_done) begin
      done_cnt++;
      done_idx     = wr_q.size();
      done_cyc     = cyc;
      done_with_wr = o_ram_wr_en;
    end
    if (o_len_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (prev_busy && !o_wr_busy) fall_cyc = cyc;
    prev_busy = o_wr_busy;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] be_mask(input logic [15:0] be);
    logic [127:0] m;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    done_cnt = 0; err_cnt = 0; done_idx = -1; done_cyc = -1;
    err_cyc = -1; fall_cyc = -1; first_wr_cyc = -1; first_acc_cyc = -2;
    done_with_wr = 1'b0;
  endtask

  // Place each payload DW at its own DW address and group by RAM line.
  task automatic build_model(input int addr, input int L, input logic [3:0] fbe, input logic [3:0] lbe);
    int         off, lines, p;
    wr_t        e;
    logic [3:0] b;
    exp_q.delete();
    off   = addr % 4;
    lines = (off + L + 3) / 4;
    for (int l = 0; l < lines; l++) begin
      e.addr = AW'(((addr / 4) + l) % (1 << AW));
      e.data = '0;
      e.be   = '0;
      for (int ln = 0; ln < 4; ln++) begin
        p = 4 * l + ln - off;
        if (p >= 0 && p < L) begin
          b = (p == 0) ? fbe : ((p == L - 1) ? lbe : 4'hF);
          e.data[32*ln +: 32] = payload[p];
          e.be[4*ln +: 4]     = b;
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic send_tlp(input int addr, input int len, input logic [3:0] fbe, input logic [3:0] lbe,
                          input int bad_beat, input int max_beats);
    int L, nb, t;
    L  = (len == 0) ? 1024 : len;
    nb = (L + 3) / 4;
    if (max_beats < nb) nb = max_beats;
    for (int i = 0; i < L; i++) payload[i] = $urandom;
    build_model(addr, L, fbe, lbe);
    clear_mon();
    @(posedge clk); #1;
    i_cpld_start   = 1'b1;
    i_cpld_length  = 10'(len);
    i_cpld_dw_addr = (AW+2)'(addr);
    i_first_be     = fbe;
    i_last_be      = lbe;
    @(posedge clk); #1;
    i_cpld_start = 1'b0;
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        i_cpld_valid = 1'b0;
        @(posedge clk); #1;
      end
      i_cpld_valid = 1'b1;
      for (int ln = 0; ln < 4; ln++)
        i_cpld_data[32*ln +: 32] = (4 * b + ln < L) ? payload[4 * b + ln] : $urandom;
      i_cpld_last = (b == (L + 3) / 4 - 1) || (b == bad_beat);
      t = 0;
      while (!o_cpld_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!o_cpld_ready) chk("ready_timeout", 128'(o_cpld_ready), 128'(1));
      @(posedge clk); #1;
      if (b == 0) first_acc_cyc = cyc;
      if (b == bad_beat) break;
    end
    i_cpld_valid = 1'b0;
    i_cpld_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_wr_busy && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("busy_timeout", 128'(o_wr_busy), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_normal();
    int n;
    chk("n_writes", 128'(wr_q.size()), 128'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 128'(wr_q[i].addr), 128'(exp_q[i].addr));
      chk("wr_be", 128'(wr_q[i].be), 128'(exp_q[i].be));
      chk("wr_data", wr_q[i].data & be_mask(exp_q[i].be), exp_q[i].data & be_mask(exp_q[i].be));
    end
    chk("done_count", 128'(done_cnt), 128'(1));
    chk("done_with_write", 128'(done_with_wr), 128'(1));
    chk("done_on_last", 128'(done_idx), 128'(exp_q.size()));
    chk("len_err_none", 128'(err_cnt), 128'(0));
    chk("busy_fall", 128'(fall_cyc), 128'(done_cyc + 1));
    chk("first_latency", 128'(first_wr_cyc), 128'(first_acc_cyc));
  endtask

  initial begin
    vecs[0] = '{addr: 'h010, len: 8, fbe: 4'hF, lbe: 4'hF, nwr: 2, a0: 'h004, be0: 16'hFFFF, alast: 'h005, belast: 16'hFFFF};
    vecs[1] = '{addr: 'h013, len: 4, fbe: 4'hF, lbe: 4'hF, nwr: 2, a0: 'h004, be0: 16'hF000, alast: 'h005, belast: 16'h0FFF};
    vecs[2] = '{addr: 'h001, len: 1, fbe: 4'h6, lbe: 4'h9, nwr: 1, a0: 'h000, be0: 16'h0060, alast: 'h000, belast: 16'h0060};
    vecs[3] = '{addr: 'h7FE, len: 4, fbe: 4'hF, lbe: 4'hF, nwr: 2, a0: 'h1FF, be0: 16'hFF00, alast: 'h000, belast: 16'h00FF};
    vecs[4] = '{addr: 'h020, len: 4, fbe: 4'hF, lbe: 4'hF, nwr: 1, a0: 'h008, be0: 16'hFFFF, alast: 'h008, belast: 16'hFFFF};
    vecs[5] = '{addr: 'h005, len: 6, fbe: 4'hE, lbe: 4'h3, nwr: 2, a0: 'h001, be0: 16'hFFE0, alast: 'h002, belast: 16'h03FF};
    vecs[6] = '{addr: 'h000, len: 0, fbe: 4'hF, lbe: 4'hF, nwr: 256, a0: 'h000, be0: 16'hFFFF, alast: 'h0FF, belast: 16'hFFFF};

    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 128'(o_ram_wr_en), 128'(0));
    chk("rst_ready", 128'(o_cpld_ready), 128'(0));
    chk("rst_busy", 128'(o_wr_busy), 128'(0));
    chk("rst_be", 128'(o_ram_wr_be), 128'(0));
    chk("rst_done_err", 128'({o_wr_done, o_len_err}), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Length mismatch: last flagged on the first of two beats.
    send_tlp('h010, 8, 4'hF, 4'hF, 0, 999);
    wait_idle();
    chk("err_pulse", 128'(err_cnt), 128'(1));
    chk("err_no_write", 128'(wr_q.size()), 128'(0));
    chk("err_no_done", 128'(done_cnt), 128'(0));
    chk("err_busy_fall", 128'(fall_cyc), 128'(err_cyc));
    send_tlp('h020, 4, 4'hF, 4'hF, -1, 999);
    wait_idle();
    check_normal();

    for (int v = 0; v < 7; v++) begin
      send_tlp(vecs[v].addr, vecs[v].len, vecs[v].fbe, vecs[v].lbe, -1, 999);
      wait_idle();
      check_normal();
      chk("tbl_nwr", 128'(wr_q.size()), 128'(vecs[v].nwr));
      if (wr_q.size() > 0) begin
        chk("tbl_a0", 128'(wr_q[0].addr), 128'(vecs[v].a0));
        chk("tbl_be0", 128'(wr_q[0].be), 128'(vecs[v].be0));
        chk("tbl_alast", 128'(wr_q[wr_q.size()-1].addr), 128'(vecs[v].alast));
        chk("tbl_belast", 128'(wr_q[wr_q.size()-1].be), 128'(vecs[v].belast));
      end
    end

    // Beats presented while idle are dropped silently.
    clear_mon();
    i_cpld_valid = 1'b1;
    i_cpld_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_cpld_valid = 1'b0;
    i_cpld_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_drop_wr", 128'(wr_q.size()), 128'(0));
    chk("idle_drop_err", 128'(err_cnt), 128'(0));
    chk("idle_drop_busy", 128'(o_wr_busy), 128'(0));

    for (int r = 0; r < 25; r++) begin
      send_tlp(int'($urandom_range(0, 2047)), int'($urandom_range(1, 40)),
               4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), -1, 999);
      wait_idle();
      check_normal();
    end

    // Reset in the middle of a 1024-DW completion.
    send_tlp(0, 0, 4'hF, 4'hF, -1, 10);
    chk("mid_busy", 128'(o_wr_busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 128'(o_ram_wr_en), 128'(0));
    chk("mid_rst_busy", 128'(o_wr_busy), 128'(0));
    chk("mid_rst_ready", 128'(o_cpld_ready), 128'(0));
    chk("mid_rst_addr_be", 128'({o_ram_wr_addr, o_ram_wr_be}), 128'(0));
    chk("mid_rst_data", o_ram_wr_data, 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_mon();
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_wr", 128'(wr_q.size()), 128'(0));
    chk("post_rst_busy", 128'(o_wr_busy), 128'(0));

    send_tlp('h013, 4, 4'hF, 4'hF, -1, 999);
    wait_idle();
    check_normal();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
